// File: rtl/io_uart_tx_sequencer.sv
// UART transmit sequencer: start bit, LSB-first data, optional even parity, stop bits.
// Define UART_TX_PARITY_EN to insert the parity bit between data and stop.
//
// state  | meaning
// IDLE   | line high, tx_ready asserted, waiting for a transfer
// START  | driving the start bit (low)
// DATA   | driving payload bit shreg[0], LSB first
// PARITY | driving even parity of the latched byte (UART_TX_PARITY_EN only)
// STOP   | driving STOP_BITS stop bits (high)
module io_uart_tx_sequencer #(
  parameter int CLOCK_FREQ = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int BIT_PERIOD = CLOCK_FREQ / BAUD_RATE,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int             TW         = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [TW-1:0]  TIMER_LAST = TW'(BIT_PERIOD - 1);
  localparam logic [3:0]     DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST  = 4'(STOP_BITS - 1);

  if (BIT_PERIOD < 2) begin : g_bad_period
    $error("io_uart_tx_sequencer: BIT_PERIOD must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("io_uart_tx_sequencer: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("io_uart_tx_sequencer: STOP_BITS must be 1 or 2");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state, state_n;
  logic [TW-1:0]        timer, timer_n;
  logic [3:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 tx_q, tx_n;
  logic                 bit_done;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_n;
`endif

  assign bit_done = (timer == TIMER_LAST);
  assign tx_ready = (state == IDLE);
  assign busy     = ~tx_ready;
  assign tx       = tx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      idx   <= '0;
      shreg <= '0;
      tx_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      timer <= timer_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      tx_q  <= tx_n;
`ifdef UART_TX_PARITY_EN
      par_q <= par_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    shreg_n = shreg;
    tx_n    = tx_q;
    timer_n = (state == IDLE || bit_done) ? '0 : timer + TW'(1);
`ifdef UART_TX_PARITY_EN
    par_n   = par_q;
`endif
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (tx_valid) begin
          state_n = START;
          tx_n    = 1'b0;
          shreg_n = tx_data;
          idx_n   = '0;
`ifdef UART_TX_PARITY_EN
          par_n   = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_done) begin
          state_n = DATA;
          idx_n   = '0;
          tx_n    = shreg[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx == DATA_LAST) begin
            idx_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = par_q;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            shreg_n = shreg >> 1;
            tx_n    = shreg[1];
            idx_n   = idx + 4'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_n = STOP;
          tx_n    = 1'b1;
          idx_n   = '0;
        end
      end
`endif
      STOP: begin
        tx_n = 1'b1;
        if (bit_done) begin
          if (idx == STOP_LAST) begin
            state_n = IDLE;
            idx_n   = '0;
          end else begin
            idx_n = idx + 4'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_io_uart_tx_sequencer.sv
// Self-checking bench for io_uart_tx_sequencer (BIT_PERIOD=10, 8N1, or 8E1 with UART_TX_PARITY_EN).
module tb_io_uart_tx_sequencer;

  localparam int BP = 10;
  localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = 1 + DB + PB + 1;
  localparam int F  = NB * BP;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy;

  int checks = 0;
  int errors = 0;

  io_uart_tx_sequencer #(
    .CLOCK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .STOP_BITS(1)
  ) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit i = line level of serial bit i (start, d0..d7, stop)
    logic       par;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference frame from the line rules: start low, LSB-first data, even parity, stop high.
  function automatic logic [11:0] model_frame(input logic [7:0] d);
    logic [11:0] lv;
    int ones;
    lv = '0;
    ones = 0;
    for (int i = 0; i < DB; i++) begin
      lv[1+i] = ((int'(d) / (1 << i)) % 2) == 1;
      ones += (int'(d) / (1 << i)) % 2;
    end
    if (PB == 1) lv[1+DB] = (ones % 2) == 1;
    lv[NB-1] = 1'b1;
    return lv;
  endfunction

  function automatic logic [11:0] table_frame(input vec_t v);
    logic [11:0] lv;
    lv = '0;
    lv[8:0] = v.frame[8:0];
    if (PB == 1) begin
      lv[9]  = v.par;
      lv[10] = 1'b1;
    end else begin
      lv[9] = 1'b1;
    end
    return lv;
  endfunction

  task automatic wait_ready(input string nm);
    int to;
    to = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && to < 300) begin
      @(negedge clk);
      to++;
    end
    chk({nm, " ready_wait"}, 32'(tx_ready), 32'd1);
  endtask

  // Sends d and checks every cycle of the frame; poke>=0 pulses tx_valid with 0xFF at that cycle.
  task automatic check_frame(input logic [7:0] d, input logic [11:0] lv, input int poke, input string nm);
    int nbad_lv, nbad_rdy, c;
    wait_ready(nm);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    nbad_rdy = 0;
    for (int b = 0; b < NB; b++) begin
      nbad_lv = 0;
      for (int k = 0; k < BP; k++) begin
        @(negedge clk);
        c = b * BP + k;
        if (c == poke) begin
          tx_data  = 8'hFF;
          tx_valid = 1'b1;
        end else if (c == poke + 1) begin
          tx_valid = 1'b0;
        end
        if (tx !== lv[b]) nbad_lv++;
        if (tx_ready !== 1'b0 || busy !== 1'b1) nbad_rdy++;
      end
      chk($sformatf("%s d=%02h bit%0d bad_cycles", nm, d, b), 32'(nbad_lv), 32'd0);
    end
    chk($sformatf("%s d=%02h busy_window bad_cycles", nm, d), 32'(nbad_rdy), 32'd0);
    @(negedge clk);
    chk($sformatf("%s d=%02h idle_after {tx_ready,busy,tx}", nm, d), 32'({tx_ready, busy, tx}), 32'b101);
  endtask

  initial begin
    int nbad, sep, nrdy;
    logic prev, exp_tx;
    logic [11:0] lv0, lv1;
    logic [7:0] d;

    vecs[0] = '{data: 8'hA5, frame: 10'h34A, par: 1'b0};
    vecs[1] = '{data: 8'h00, frame: 10'h200, par: 1'b0};
    vecs[2] = '{data: 8'hFF, frame: 10'h3FE, par: 1'b0};
    vecs[3] = '{data: 8'h55, frame: 10'h2AA, par: 1'b0};
    vecs[4] = '{data: 8'h07, frame: 10'h20E, par: 1'b1};
    vecs[5] = '{data: 8'h3C, frame: 10'h278, par: 1'b0};

    // reset and idle
    repeat (3) @(negedge clk);
    chk("in_reset {tx,tx_ready,busy}", 32'({tx, tx_ready, busy}), 32'b110);
    reset = 1'b0;
    nbad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) nbad++;
    end
    chk("idle_20 bad_cycles", 32'(nbad), 32'd0);

    // table-driven frames
    foreach (vecs[i]) check_frame(vecs[i].data, table_frame(vecs[i]), -1, "table");

    // back-to-back with tx_valid held: 0x00 then 0xFF
    wait_ready("b2b");
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_data = 8'hFF;
    lv0 = table_frame(vecs[1]);
    lv1 = table_frame(vecs[2]);
    nbad = 0;
    nrdy = 0;
    sep  = -1;
    prev = 1'b0;
    for (int c = 0; c <= 2 * F; c++) begin
      @(negedge clk);
      if (c == F + 1) tx_valid = 1'b0;
      if (c < F) exp_tx = lv0[c / BP];
      else if (c == F) exp_tx = 1'b1;
      else exp_tx = lv1[(c - F - 1) / BP];
      if (tx !== exp_tx) nbad++;
      if (tx_ready !== (c == F)) nrdy++;
      if (c > 0 && sep < 0 && prev === 1'b1 && tx === 1'b0) sep = c;
      prev = tx;
    end
    chk("b2b line bad_cycles", 32'(nbad), 32'd0);
    chk("b2b ready bad_cycles", 32'(nrdy), 32'd0);
    chk("b2b start_separation", 32'(sep), 32'(F + 1));
    @(negedge clk);
    chk("b2b idle_after {tx_ready,busy,tx}", 32'({tx_ready, busy, tx}), 32'b101);

    // data change and tx_valid pulse mid-frame are ignored
    check_frame(8'h3C, table_frame(vecs[5]), 40, "midframe_poke");
    nbad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_ready !== 1'b1) nbad++;
    end
    chk("midframe_poke no_second_frame bad_cycles", 32'(nbad), 32'd0);

    // reset at clock 35 of a frame
    wait_ready("reset_mid");
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (35) @(negedge clk);
    chk("reset_mid tx_before", 32'(tx), 32'd0);
    #1 reset = 1'b1;
    #1 chk("reset_mid async {tx,tx_ready,busy}", 32'({tx, tx_ready, busy}), 32'b110);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    nbad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_ready !== 1'b1) nbad++;
    end
    chk("reset_mid no_resume bad_cycles", 32'(nbad), 32'd0);
    check_frame(8'h55, table_frame(vecs[3]), -1, "after_reset");

    // random bytes against the reference model
    for (int n = 0; n < 20; n++) begin
      d = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check_frame(d, model_frame(d), -1, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_uart_tx_sequencer.md
Name: io_uart_tx_sequencer

Overview:
UART transmit controller that sequences one serial frame per accepted byte: start bit, data bits LSB-first, an optional parity bit, and stop bits.
It owns a bit-period timer that restarts at the start of each frame. This differs from a free-running baud tick, so every bit is exactly BIT_PERIOD clocks long.
It sits between the core's I/O register write path (valid/ready) and the board TX pin.

Parameters:
CLOCK_FREQ, 100000000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bits/s
BIT_PERIOD, CLOCK_FREQ / BAUD_RATE, clocks per serial bit; must be >= 2 (elaboration-time assertion)
DATA_BITS, 8, payload bits per frame, legal range 5..9
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
tx_data  input  DATA_BITS  byte to transmit; sampled only on handshake
tx_valid  input  1  requester has data
tx_ready  output  1  block can accept; high only in IDLE
tx  output  1  serial line, idle high, registered
busy  output  1  frame in progress; equals the inverse of tx_ready

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, tx = 1, tx_ready = 1, busy = 0
  - bit timer = 0, bit index = 0, shift register = 0
- Bit timer: width ceil_log2(BIT_PERIOD); counts 0..BIT_PERIOD-1.
  - bit_done = (timer == BIT_PERIOD-1); on bit_done the timer wraps to 0.
  - Timer is held at 0 in IDLE.
- Handshake: a transfer occurs on a rising edge where tx_valid && tx_ready.
  - tx_ready is combinational from state (state == IDLE).
  - On the transfer edge: latch tx_data into the shift register, state -> START, tx <= 0.
  - The start bit is visible from the cycle after the handshake.
- State machine:
  - IDLE: tx = 1; on transfer -> START.
  - START: tx = 0; on bit_done -> DATA, bit index = 0, tx <= shreg[0].
  - DATA: tx = current bit. On bit_done: if index == DATA_BITS-1, go to PARITY (if enabled) or STOP; otherwise shift right, index++.
  - PARITY: see Optional Feature.
  - STOP: tx = 1 for STOP_BITS*BIT_PERIOD clocks, then -> IDLE.
- Frame length:
  - F = (1 + DATA_BITS [+1 parity] + STOP_BITS) * BIT_PERIOD clocks of tx activity, measured from the first start-bit cycle.
  - With tx_valid held high, consecutive start bits are F+1 clocks apart: one IDLE cycle between frames, on which the next transfer occurs.
- tx_valid and tx_data are ignored while busy; a data change mid-frame has no effect on the frame in flight.
- Reset mid-frame: tx returns to 1 asynchronously and the frame is dropped with no partial retransmit. After reset deasserts, the first transfer produces a normal full frame.
- tx never glitches: it changes only on the clock edge at bit boundaries and on the handshake edge.

Optional Feature:
Macro: UART_TX_PARITY_EN
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - tx = XOR of all latched data bits (even parity) for BIT_PERIOD clocks.
  - F grows by BIT_PERIOD.
- Undefined:
  - No PARITY state or parity logic exists.
  - DATA exits directly to STOP.

Test Plan:
All tests use CLOCK_FREQ=1000, BAUD_RATE=100 (BIT_PERIOD=10), DATA_BITS=8, STOP_BITS=1.
1. Assert reset, release, idle 20 clocks -> tx=1, tx_ready=1, busy=0 throughout.
2. Send 0xA5 with one-cycle tx_valid -> starting the cycle after the handshake, tx = 0,1,0,1,0,0,1,0,1,1, each level held exactly 10 clocks. tx_ready is low for 100 clocks, then high.
3. Hold tx_valid high with 0x00 then 0xFF -> second start bit begins exactly 101 clocks after the first. Line shows 9 lows, 1 high, then start 0 followed by 8 highs and the stop bit.
4. During a 0x3C frame, change tx_data to 0xFF and pulse tx_valid at clock 40 -> frame still carries 0x3C, no second frame is sent, and tx_ready stays low until clock 100.
5. Assert reset at clock 35 of a frame -> tx=1 in the same cycle and tx_ready=1. After release, sending 0x55 yields a correct full 100-clock frame.
6. Build with UART_TX_PARITY_EN and send 0x07 -> parity bit = 1 at clocks 90..99, stop bit at clocks 100..109, tx_ready returns after 110 clocks.
